// File: rtl/tow_referee_pkg.sv
// Shared types and constants for the tug-of-war referee: FSM states,
// score width and active-low 7-segment digit patterns (bit 0 = seg a).
package tow_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    ROUND_END  = 2'd1,
    MATCH_OVER = 2'd2
  } ref_state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/tow_referee_if.sv
// Signal bundle between the playfield/keys side (master) and the referee (slave).
interface tow_referee_if;
  import tow_pkg::*;

  logic               L;
  logic               R;
  logic               leftEnd;
  logic               rightEnd;
  logic               restart;
  logic [SCORE_W-1:0] leftScore;
  logic [SCORE_W-1:0] rightScore;
  logic               leftWins;
  logic               rightWins;
  logic [6:0]         leftHex;
  logic [6:0]         rightHex;

  modport master (
    output L, R, leftEnd, rightEnd,
    input  restart, leftScore, rightScore, leftWins, rightWins, leftHex, rightHex
  );

  modport slave (
    input  L, R, leftEnd, rightEnd,
    output restart, leftScore, rightScore, leftWins, rightWins, leftHex, rightHex
  );
endinterface

// File: rtl/seg7_digit.sv
// Combinational decode of a 4-bit value to an active-low 7-segment pattern;
// values above 9 blank the digit.
module seg7_digit
  import tow_pkg::*;
(
  input  logic [SCORE_W-1:0] i_value,
  output logic [6:0]         o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_value)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tow_referee.sv
// Tug-of-war scoring and round control: awards points when the lit end light
// is pushed off, pulses restart to the playfield and freezes the match on a win.
module tow_referee
  import tow_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 7
) (
  input  logic          Clock,
  input  logic          Reset,
  tow_referee_if.slave  bus
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  ref_state_t         r_state, w_state_next;
  logic [SCORE_W-1:0] r_left_score, w_left_score_next;
  logic [SCORE_W-1:0] r_right_score, w_right_score_next;
  logic               r_left_wins, w_left_wins_next;
  logic               r_right_wins, w_right_wins_next;
  logic               w_left_pt, w_right_pt;
  logic [SCORE_W-1:0] w_left_inc, w_right_inc;

  // The key terms are mutually exclusive, so at most one point fires per cycle.
  assign w_left_pt   = bus.leftEnd  & bus.L & ~bus.R;
  assign w_right_pt  = bus.rightEnd & bus.R & ~bus.L;
  assign w_left_inc  = r_left_score  + 1'b1;
  assign w_right_inc = r_right_score + 1'b1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state       <= PLAY;
      r_left_score  <= '0;
      r_right_score <= '0;
      r_left_wins   <= 1'b0;
      r_right_wins  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_left_score  <= w_left_score_next;
      r_right_score <= w_right_score_next;
      r_left_wins   <= w_left_wins_next;
      r_right_wins  <= w_right_wins_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_left_score_next  = r_left_score;
    w_right_score_next = r_right_score;
    w_left_wins_next   = r_left_wins;
    w_right_wins_next  = r_right_wins;
    case (r_state)
      PLAY: begin
        if (w_left_pt) begin
          w_left_score_next = w_left_inc;
          if (w_left_inc == WIN_VAL) begin
            w_left_wins_next = 1'b1;
            w_state_next     = MATCH_OVER;
          end else begin
            w_state_next = ROUND_END;
          end
        end else if (w_right_pt) begin
          w_right_score_next = w_right_inc;
          if (w_right_inc == WIN_VAL) begin
            w_right_wins_next = 1'b1;
            w_state_next      = MATCH_OVER;
          end else begin
            w_state_next = ROUND_END;
          end
        end
      end
      ROUND_END:  w_state_next = PLAY;
      MATCH_OVER: w_state_next = MATCH_OVER;
      default:    w_state_next = PLAY;
    endcase
  end

  assign bus.restart    = (r_state != PLAY);
  assign bus.leftScore  = r_left_score;
  assign bus.rightScore = r_right_score;
  assign bus.leftWins   = r_left_wins;
  assign bus.rightWins  = r_right_wins;

  seg7_digit u_left_hex (
    .i_value (r_left_score),
    .o_seg   (bus.leftHex)
  );

  seg7_digit u_right_hex (
    .i_value (r_right_score),
    .o_seg   (bus.rightHex)
  );

endmodule

// File: tb/tb_tow_referee.sv
// Directed bench for tow_referee: a game-level score model checked every
// falling edge, plus literal expectations at the interesting moments.
module tb_tow_referee;

  localparam int WIN = 7;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  tow_referee_if bus ();

  tow_referee #(.WIN_SCORE(WIN)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;

  // Game-level model: scores, who has won, and whether a restart cycle is owed.
  int m_ls = 0;
  int m_rs = 0;
  bit m_lw = 1'b0;
  bit m_rw = 1'b0;
  bit m_round_end = 1'b0;

  logic [6:0] digit_tbl [0:9];

  function automatic logic [6:0] exp_hex(int v);
    if (v > 9) return 7'h7F;
    return digit_tbl[v];
  endfunction

  task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_ls <= 0; m_rs <= 0; m_lw <= 1'b0; m_rw <= 1'b0; m_round_end <= 1'b0;
    end else if (m_round_end) begin
      m_round_end <= 1'b0;
    end else if (!m_lw && !m_rw) begin
      if (bus.leftEnd && bus.L && !bus.R) begin
        m_ls <= m_ls + 1;
        if (m_ls + 1 == WIN) m_lw <= 1'b1; else m_round_end <= 1'b1;
      end else if (bus.rightEnd && bus.R && !bus.L) begin
        m_rs <= m_rs + 1;
        if (m_rs + 1 == WIN) m_rw <= 1'b1; else m_round_end <= 1'b1;
      end
    end
  end

  always @(negedge Clock) begin
    if (!Reset) begin
      chk("model_leftScore",  7'(bus.leftScore),  7'(m_ls));
      chk("model_rightScore", 7'(bus.rightScore), 7'(m_rs));
      chk("model_leftWins",   7'(bus.leftWins),   7'(m_lw));
      chk("model_rightWins",  7'(bus.rightWins),  7'(m_rw));
      chk("model_restart",    7'(bus.restart),    7'(m_round_end || m_lw || m_rw));
      chk("model_leftHex",    bus.leftHex,  exp_hex(m_ls));
      chk("model_rightHex",   bus.rightHex, exp_hex(m_rs));
      $display("cycle t=%0t L=%0d R=%0d score=%0d:%0d wins=%0d:%0d restart=%0d",
               $time, bus.L, bus.R, bus.leftScore, bus.rightScore,
               bus.leftWins, bus.rightWins, bus.restart);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Hold the given inputs across one rising edge, then release them.
  task automatic drive(input logic l, input logic r, input logic le, input logic re);
    bus.L = l; bus.R = r; bus.leftEnd = le; bus.rightEnd = re;
    tick();
    bus.L = 1'b0; bus.R = 1'b0; bus.leftEnd = 1'b0; bus.rightEnd = 1'b0;
  endtask

  initial begin
    digit_tbl[0] = 7'h40; digit_tbl[1] = 7'h79; digit_tbl[2] = 7'h24;
    digit_tbl[3] = 7'h30; digit_tbl[4] = 7'h19; digit_tbl[5] = 7'h12;
    digit_tbl[6] = 7'h02; digit_tbl[7] = 7'h78; digit_tbl[8] = 7'h00;
    digit_tbl[9] = 7'h10;
    bus.L = 1'b0; bus.R = 1'b0; bus.leftEnd = 1'b0; bus.rightEnd = 1'b0;

    #2;
    chk("rst_leftScore",  7'(bus.leftScore),  7'd0);
    chk("rst_rightScore", 7'(bus.rightScore), 7'd0);
    chk("rst_restart",    7'(bus.restart),    7'd0);
    chk("rst_wins",       7'({bus.leftWins, bus.rightWins}), 7'd0);
    chk("rst_leftHex",    bus.leftHex,  7'h40);
    chk("rst_rightHex",   bus.rightHex, 7'h40);
    tick(); tick();
    Reset = 1'b0;
    tick();

    // First left point: score 1, restart for exactly one cycle.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("lp1_leftScore", 7'(bus.leftScore), 7'd1);
    chk("lp1_leftHex",   bus.leftHex, 7'h79);
    chk("lp1_restart",   7'(bus.restart), 7'd1);
    tick();
    chk("lp1_restart_drop", 7'(bus.restart), 7'd0);

    // Both keys together never score.
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("lr_rightScore", 7'(bus.rightScore), 7'd0);
    chk("lr_restart",    7'(bus.restart), 7'd0);
    tick();

    // Wrong player pressing at the lit end.
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("wrong_leftScore", 7'(bus.leftScore), 7'd1);
    chk("wrong_restart",   7'(bus.restart), 7'd0);
    tick();

    // Point, then another point attempt on the restart cycle is ignored.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("re_first", 7'(bus.leftScore), 7'd2);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("re_ignored", 7'(bus.leftScore), 7'd2);
    chk("re_hex",     bus.leftHex, 7'h24);
    chk("re_play",    7'(bus.restart), 7'd0);

    // Press in the cycle right after restart is evaluated normally.
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    chk("after_re_rightScore", 7'(bus.rightScore), 7'd1);
    tick(); tick();

    // Right player runs to the win.
    for (int i = 2; i <= WIN; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      chk("rp_rightScore", 7'(bus.rightScore), 7'(i));
      tick(); tick();
    end
    chk("win_rightWins", 7'(bus.rightWins), 7'd1);
    chk("win_leftWins",  7'(bus.leftWins),  7'd0);
    chk("win_restart",   7'(bus.restart),   7'd1);
    chk("win_rightHex",  bus.rightHex, 7'h78);

    // Match is frozen.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("frozen_leftScore",  7'(bus.leftScore),  7'd2);
    chk("frozen_rightScore", 7'(bus.rightScore), 7'd7);
    chk("frozen_restart",    7'(bus.restart),    7'd1);

    // Asynchronous reset between edges.
    #3;
    Reset = 1'b1;
    #1;
    chk("arst_restart",    7'(bus.restart),    7'd0);
    chk("arst_rightScore", 7'(bus.rightScore), 7'd0);
    chk("arst_leftScore",  7'(bus.leftScore),  7'd0);
    chk("arst_wins",       7'({bus.leftWins, bus.rightWins}), 7'd0);
    chk("arst_rightHex",   bus.rightHex, 7'h40);
    tick();
    Reset = 1'b0;
    tick();

    // Left player wins; first point taken with both end lights lit.
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk("post_rst_leftScore", 7'(bus.leftScore), 7'd1);
    tick(); tick();
    for (int i = 2; i <= WIN; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      tick(); tick();
    end
    chk("lwin_leftScore", 7'(bus.leftScore), 7'd7);
    chk("lwin_leftWins",  7'(bus.leftWins),  7'd1);
    chk("lwin_rightWins", 7'(bus.rightWins), 7'd0);
    chk("lwin_restart",   7'(bus.restart),   7'd1);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
